// File: rtl/timer_controller.sv
`default_nettype none
// ============================================================================
// Module      : timer_controller
// Description : MM:SS BCD countdown timer with 1 Hz prescaler and state FSM.
//               Optional EXPIRED blink enabled by defining TIMER_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_controller #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BLINK_CYC = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_START,
    input  logic       BTN_STOP,
    input  logic       BTN_CLEAR,
    input  logic       BTN_INC_MIN,
    input  logic       BTN_INC_SEC,
    output logic [3:0] DIGIT_3,
    output logic [3:0] DIGIT_2,
    output logic [3:0] DIGIT_1,
    output logic [3:0] DIGIT_0,
    output logic [3:0] BLANK,
    output logic       DONE,
    output logic [1:0] STATE
);

    localparam int c_PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSE   = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_d3, r_d2, r_d1, r_d0;
    logic [3:0]             w_d3_nxt, w_d2_nxt, w_d1_nxt, w_d0_nxt;
    logic [3:0]             w_dec_d3, w_dec_d2, w_dec_d1, w_dec_d0;
    logic [c_PRESC_W-1:0]   r_presc, w_presc_nxt;
    logic                   r_done, w_done_nxt;
    logic                   w_clear, w_stop, w_start, w_inc_min, w_inc_sec;
    logic                   w_tick, w_time_nz, w_dec_zero, w_any_ctrl;

    // Only the highest-priority button of a cycle is acted on
    assign w_clear    = BTN_CLEAR;
    assign w_stop     = BTN_STOP & ~BTN_CLEAR;
    assign w_start    = BTN_START & ~BTN_STOP & ~BTN_CLEAR;
    assign w_inc_min  = BTN_INC_MIN & ~BTN_START & ~BTN_STOP & ~BTN_CLEAR;
    assign w_inc_sec  = BTN_INC_SEC & ~BTN_INC_MIN & ~BTN_START & ~BTN_STOP & ~BTN_CLEAR;
    assign w_any_ctrl = BTN_START | BTN_STOP | BTN_CLEAR;

    assign w_tick     = (r_presc == c_PRESC_MAX);
    assign w_time_nz  = |{r_d3, r_d2, r_d1, r_d0};
    assign w_dec_zero = ~|{w_dec_d3, w_dec_d2, w_dec_d1, w_dec_d0};

    always_comb begin
        w_dec_d3 = r_d3;
        w_dec_d2 = r_d2;
        w_dec_d1 = r_d1;
        w_dec_d0 = r_d0 - 4'd1;
        if (r_d0 == 4'd0) begin
            w_dec_d0 = 4'd9;
            w_dec_d1 = r_d1 - 4'd1;
            if (r_d1 == 4'd0) begin
                w_dec_d1 = 4'd5;
                w_dec_d2 = r_d2 - 4'd1;
                if (r_d2 == 4'd0) begin
                    w_dec_d2 = 4'd9;
                    w_dec_d3 = r_d3 - 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_d3_nxt    = r_d3;
        w_d2_nxt    = r_d2;
        w_d1_nxt    = r_d1;
        w_d0_nxt    = r_d0;
        w_presc_nxt = r_presc;
        w_done_nxt  = r_done;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_time_nz) begin
                        w_state_nxt = S_RUN;
                        w_presc_nxt = '0;
                    end
                end else if (w_inc_min) begin
                    if (r_d2 == 4'd9) begin
                        w_d2_nxt = 4'd0;
                        w_d3_nxt = (r_d3 == 4'd9) ? 4'd0 : r_d3 + 4'd1;
                    end else begin
                        w_d2_nxt = r_d2 + 4'd1;
                    end
                end else if (w_inc_sec) begin
                    if (r_d0 == 4'd9) begin
                        w_d0_nxt = 4'd0;
                        w_d1_nxt = (r_d1 == 4'd5) ? 4'd0 : r_d1 + 4'd1;
                    end else begin
                        w_d0_nxt = r_d0 + 4'd1;
                    end
                end
            end
            S_RUN: begin
                if (w_clear) begin
                    w_state_nxt = S_IDLE;
                    {w_d3_nxt, w_d2_nxt, w_d1_nxt, w_d0_nxt} = '0;
                    w_presc_nxt = '0;
                end else begin
                    // A STOP cycle still counts as a running cycle
                    w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
                    if (w_stop) w_state_nxt = S_PAUSE;
                    if (w_tick) begin
                        {w_d3_nxt, w_d2_nxt, w_d1_nxt, w_d0_nxt} =
                            {w_dec_d3, w_dec_d2, w_dec_d1, w_dec_d0};
                        if (w_dec_zero) begin
                            w_state_nxt = S_EXPIRED;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (w_clear) begin
                    w_state_nxt = S_IDLE;
                    {w_d3_nxt, w_d2_nxt, w_d1_nxt, w_d0_nxt} = '0;
                    w_presc_nxt = '0;
                end else if (w_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_EXPIRED: begin
                if (w_any_ctrl) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_d3    <= '0;
            r_d2    <= '0;
            r_d1    <= '0;
            r_d0    <= '0;
            r_presc <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_d3    <= w_d3_nxt;
            r_d2    <= w_d2_nxt;
            r_d1    <= w_d1_nxt;
            r_d0    <= w_d0_nxt;
            r_presc <= w_presc_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef TIMER_BLINK_EN
    localparam int c_BLINK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [c_BLINK_W-1:0] c_BLINK_MAX = c_BLINK_W'(BLINK_CYC - 1);

    logic [c_BLINK_W-1:0] r_blink;
    logic [3:0]           r_blank;

    // Counter only runs while staying in EXPIRED; entry and exit clear it
    always_ff @(posedge CLK) begin
        if (RST || (r_state != S_EXPIRED) || (w_state_nxt != S_EXPIRED)) begin
            r_blink <= '0;
            r_blank <= 4'b0000;
        end else if (r_blink == c_BLINK_MAX) begin
            r_blink <= '0;
            r_blank <= ~r_blank;
        end else begin
            r_blink <= r_blink + 1'b1;
        end
    end

    assign BLANK = r_blank;
`else
    assign BLANK = 4'b0000;
`endif

    assign DIGIT_3 = r_d3;
    assign DIGIT_2 = r_d2;
    assign DIGIT_1 = r_d1;
    assign DIGIT_0 = r_d0;
    assign DONE    = r_done;
    assign STATE   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_timer_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_controller
// Description : Self-checking bench for timer_controller (CLK_HZ=10, BLINK_CYC=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_controller;

    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_SEC   = 5'b00001;
    localparam logic [4:0] B_MIN   = 5'b00010;
    localparam logic [4:0] B_START = 5'b00100;
    localparam logic [4:0] B_STOP  = 5'b01000;
    localparam logic [4:0] B_CLR   = 5'b10000;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BTN_START = 1'b0, BTN_STOP = 1'b0, BTN_CLEAR = 1'b0;
    logic       BTN_INC_MIN = 1'b0, BTN_INC_SEC = 1'b0;
    logic [3:0] DIGIT_3, DIGIT_2, DIGIT_1, DIGIT_0, BLANK;
    logic       DONE;
    logic [1:0] STATE;

    timer_controller #(.CLK_HZ(10), .BLINK_CYC(4)) dut (
        .CLK(CLK), .RST(RST),
        .BTN_START(BTN_START), .BTN_STOP(BTN_STOP), .BTN_CLEAR(BTN_CLEAR),
        .BTN_INC_MIN(BTN_INC_MIN), .BTN_INC_SEC(BTN_INC_SEC),
        .DIGIT_3(DIGIT_3), .DIGIT_2(DIGIT_2), .DIGIT_1(DIGIT_1), .DIGIT_0(DIGIT_0),
        .BLANK(BLANK), .DONE(DONE), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  blank;
        logic        done;
        logic [1:0]  st;
    } exp_t;

    typedef struct {
        logic [4:0]  btn;
        logic [15:0] dig;
        logic [1:0]  st;
    } vec_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic exp_t mk(input logic [15:0] d, input logic [1:0] s,
                                input logic dn, input logic [3:0] bl);
        exp_t e;
        e.dig = d; e.blank = bl; e.done = dn; e.st = s;
        return e;
    endfunction

    function automatic logic [3:0] blink_exp(input int k);
`ifdef TIMER_BLINK_EN
        return (((k / 4) % 2) == 1) ? 4'hF : 4'h0;
`else
        return (k < 0) ? 4'hF : 4'h0;
`endif
    endfunction

    task automatic compare(input string tag);
        exp_t e;
        exp_t a;
        n_chk++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb_q.pop_front();
        a = {DIGIT_3, DIGIT_2, DIGIT_1, DIGIT_0, BLANK, DONE, STATE};
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got digits=%h blank=%b done=%b state=%0d, required digits=%h blank=%b done=%b state=%0d",
                     tag, a.dig, a.blank, a.done, a.st, e.dig, e.blank, e.done, e.st);
        end
    endtask

    task automatic cycle(input logic [4:0] b);
        @(negedge CLK);
        {BTN_CLEAR, BTN_STOP, BTN_START, BTN_INC_MIN, BTN_INC_SEC} = b;
        @(posedge CLK);
        #1;
        {BTN_CLEAR, BTN_STOP, BTN_START, BTN_INC_MIN, BTN_INC_SEC} = B_NONE;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(B_NONE);
    endtask

    task automatic step(input logic [4:0] b, input exp_t e, input string tag);
        sb_q.push_back(e);
        cycle(b);
        compare(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        sb_q.push_back(mk(16'h0000, 2'd0, 1'b0, 4'h0));
        compare(tag);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{B_MIN,           16'h0100, 2'd0};
        tbl[1] = '{B_MIN,           16'h0200, 2'd0};
        tbl[2] = '{B_SEC,           16'h0201, 2'd0};
        tbl[3] = '{B_SEC,           16'h0202, 2'd0};
        tbl[4] = '{B_SEC,           16'h0203, 2'd0};
        tbl[5] = '{B_STOP,          16'h0203, 2'd0};
        tbl[6] = '{B_CLR,           16'h0203, 2'd0};
        tbl[7] = '{B_CLR | B_START, 16'h0203, 2'd0};
        tbl[8] = '{B_MIN | B_SEC,   16'h0303, 2'd0};
        tbl[9] = '{B_STOP | B_START,16'h0303, 2'd0};

        do_reset("reset");
        for (int i = 0; i < 10; i++)
            step(tbl[i].btn, mk(tbl[i].dig, tbl[i].st, 1'b0, 4'h0), $sformatf("idle_vec%0d", i));

        // Seconds wrap without carry into minutes
        do_reset("reset_sec");
        cycle(B_MIN);
        for (int i = 0; i < 58; i++) cycle(B_SEC);
        step(B_SEC, mk(16'h0159, 2'd0, 1'b0, 4'h0), "sec_59");
        step(B_SEC, mk(16'h0100, 2'd0, 1'b0, 4'h0), "sec_wrap");

        // Minutes wrap and START at zero
        do_reset("reset_min");
        for (int i = 0; i < 98; i++) cycle(B_MIN);
        step(B_MIN, mk(16'h9900, 2'd0, 1'b0, 4'h0), "min_99");
        step(B_MIN, mk(16'h0000, 2'd0, 1'b0, 4'h0), "min_wrap");
        step(B_START, mk(16'h0000, 2'd0, 1'b0, 4'h0), "start_zero");

        // Countdown to expiry and blink
        do_reset("reset_run");
        cycle(B_SEC);
        cycle(B_SEC);
        step(B_START, mk(16'h0002, 2'd1, 1'b0, 4'h0), "run_enter");
        idle(8);
        step(B_NONE, mk(16'h0002, 2'd1, 1'b0, 4'h0), "pre_tick");
        step(B_NONE, mk(16'h0001, 2'd1, 1'b0, 4'h0), "tick1");
        idle(9);
        step(B_NONE, mk(16'h0000, 2'd3, 1'b1, 4'h0), "expire");
        step(B_MIN, mk(16'h0000, 2'd3, 1'b1, blink_exp(1)), "expired_inc");
        for (int k = 2; k <= 9; k++)
            step(B_NONE, mk(16'h0000, 2'd3, 1'b1, blink_exp(k)), $sformatf("blink_k%0d", k));
        step(B_STOP, mk(16'h0000, 2'd0, 1'b0, 4'h0), "expired_exit");

        // Borrow across digits, INC ignored while running
        do_reset("reset_borrow");
        for (int i = 0; i < 10; i++) cycle(B_MIN);
        step(B_START, mk(16'h1000, 2'd1, 1'b0, 4'h0), "start_1000");
        step(B_MIN, mk(16'h1000, 2'd1, 1'b0, 4'h0), "inc_in_run");
        idle(7);
        step(B_NONE, mk(16'h1000, 2'd1, 1'b0, 4'h0), "pre_borrow");
        step(B_NONE, mk(16'h0959, 2'd1, 1'b0, 4'h0), "tick_borrow");

        // Pause holds the prescaler phase
        idle(3);
        step(B_STOP, mk(16'h0959, 2'd2, 1'b0, 4'h0), "stop");
        idle(49);
        step(B_NONE, mk(16'h0959, 2'd2, 1'b0, 4'h0), "pause_hold");
        step(B_MIN, mk(16'h0959, 2'd2, 1'b0, 4'h0), "inc_in_pause");
        step(B_START, mk(16'h0959, 2'd1, 1'b0, 4'h0), "resume");
        idle(4);
        step(B_NONE, mk(16'h0959, 2'd1, 1'b0, 4'h0), "resume_pre");
        step(B_NONE, mk(16'h0958, 2'd1, 1'b0, 4'h0), "resume_tick");
        step(B_CLR | B_START, mk(16'h0000, 2'd0, 1'b0, 4'h0), "clear_run");

        // STOP coinciding with a tick, then CLEAR from PAUSE
        do_reset("reset_stoptick");
        for (int i = 0; i < 3; i++) cycle(B_SEC);
        step(B_START, mk(16'h0003, 2'd1, 1'b0, 4'h0), "start_0003");
        idle(9);
        step(B_STOP, mk(16'h0002, 2'd2, 1'b0, 4'h0), "stop_tick");
        step(B_CLR, mk(16'h0000, 2'd0, 1'b0, 4'h0), "clear_pause");

        // Reset mid-run
        cycle(B_MIN);
        cycle(B_START);
        idle(3);
        do_reset("rst_run");
        step(B_NONE, mk(16'h0000, 2'd0, 1'b0, 4'h0), "rst_run_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
